// File: rtl/rv_pkg.sv
// Shared register-file types and sizes.
// Used by the decode and writeback side of the pipelined core.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard.
// Reserves destinations at issue, releases them at writeback.
module reg_scoreboard
  import rv_pkg::*;
#(
  parameter int DEPTH = REG_COUNT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic          rel_en,
  input  logic [AW-1:0] rel_addr,
  output logic [DEPTH-1:0] busy,
  output logic [AW:0]   busy_count
);

  logic [DEPTH-1:0] busy_n;
  logic [AW:0]      count_n;
  logic             set;
  logic             inc;
  logic             dec;

  // A busy destination may be re-reserved only when it is released now.
  assign issue_ready = !flush &&
    (issue_rd == '0 || !busy[issue_rd] ||
     (rel_en && rel_addr == issue_rd));

  assign set = issue_valid && issue_ready && issue_rd != '0;
  assign inc = set && !busy[issue_rd];
  assign dec = rel_en && busy[rel_addr] &&
    !(set && issue_rd == rel_addr);

  // Next busy vector and count: release, then set, flush overrides all.
  always_comb begin
    busy_n  = busy;
    count_n = busy_count + (AW+1)'(inc) - (AW+1)'(dec);
    if (rel_en)
      busy_n[rel_addr] = 1'b0;
    if (set)
      busy_n[issue_rd] = 1'b1;
    if (flush) begin
      busy_n  = '0;
      count_n = '0;
    end
  end

  // Busy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_n;
      busy_count <= count_n;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with writeback bypass.
// Busy scoreboard for RAW stalls and destination reservation.
module reg_file_sb
  import rv_pkg::*;
#(
  parameter int XLEN_P   = XLEN,
  parameter int DEPTH    = REG_COUNT,
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_READ*AW-1:0]   rs_addr,
  output logic [NUM_READ*XLEN_P-1:0] rs_data,
  output logic [NUM_READ-1:0]      rs_busy,
  input  logic [AW-1:0]            rd_addr,
  input  logic [XLEN_P-1:0]        rd_data,
  input  logic                     reg_write_enable,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_rd,
  output logic                     issue_ready,
  input  logic                     flush,
  output logic [AW:0]              busy_count,
  input  logic [AW-1:0]            dbg_addr,
  output logic [XLEN_P-1:0]        dbg_data
);

  logic [XLEN_P-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  reg_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rel_en      (reg_write_enable),
    .rel_addr    (rd_addr),
    .busy        (busy),
    .busy_count  (busy_count)
  );

  // Register array; register 0 is never written and stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (reg_write_enable && rd_addr != '0) begin
      regs[rd_addr] <= rd_data;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;

    assign a   = rs_addr[i*AW +: AW];
    assign hit = (BYPASS != 0) && reg_write_enable &&
                 rd_addr == a && a != '0;

    assign rs_data[i*XLEN_P +: XLEN_P] =
      (a == '0) ? '0 : (hit ? rd_data : regs[a]);
    assign rs_busy[i] = busy[a] && !hit;
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb.
// Two instances share stimulus: bypass on and bypass off.
module tb_reg_file_sb;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*AW-1:0] rs_addr;
  logic [63:0]   rs_data, nb_rs_data;
  logic [1:0]    rs_busy, nb_rs_busy;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          reg_write_enable;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_ready, nb_issue_ready;
  logic          flush;
  logic [AW:0]   busy_count, nb_busy_count;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_data, nb_dbg_data;

  always #5 clk = ~clk;

  reg_file_sb #(.BYPASS(1)) u_dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .reg_write_enable(reg_write_enable),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .flush(flush),
    .busy_count(busy_count),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  reg_file_sb #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rs_data(nb_rs_data), .rs_busy(nb_rs_busy),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .reg_write_enable(reg_write_enable),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(nb_issue_ready), .flush(flush),
    .busy_count(nb_busy_count),
    .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      0: return rs_data[31:0];
      1: return rs_data[63:32];
      2: return 32'(rs_busy[0]);
      3: return 32'(rs_busy[1]);
      4: return 32'(busy_count);
      5: return 32'(issue_ready);
      6: return dbg_data;
      7: return nb_rs_data[31:0];
      8: return 32'(nb_rs_busy[1]);
      default: return 'x;
    endcase
  endfunction

  task automatic expect_val(string n, int sel, logic [31:0] v);
    sbq.push_back('{n, sel, v});
  endtask

  // Monitor: check every queued expectation mid-cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = sbq.pop_front();
      a = actual(e.sel);
      total++;
      if (a !== e.val) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, a, e.val);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write_enable = 1'b0;
    issue_valid      = 1'b0;
    flush            = 1'b0;
    rd_addr          = '0;
    rd_data          = '0;
    issue_rd         = '0;
  endtask

  initial begin
    rst      = 1'b1;
    rs_addr  = '0;
    dbg_addr = '0;
    idle();

    // reset state
    cyc();
    dbg_addr = 5'd5;
    rs_addr  = {5'd0, 5'd6};
    expect_val("rst_count", 4, 0);
    expect_val("rst_ready", 5, 1);
    expect_val("rst_rsdata", 0, 0);
    expect_val("rst_rsbusy", 2, 0);
    expect_val("rst_dbg", 6, 0);

    // write r5, reserve r6
    cyc();
    rst = 1'b0;
    reg_write_enable = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
    issue_valid = 1'b1; issue_rd = 5'd6;
    cyc();
    idle();
    expect_val("pre_rst_dbg5", 6, 32'hDEADBEEF);
    expect_val("pre_rst_count", 4, 1);
    expect_val("pre_rst_busy6", 2, 1);

    // reset mid-operation with a concurrent write
    cyc();
    rst = 1'b1;
    reg_write_enable = 1'b1; rd_addr = 5'd5; rd_data = 32'h11;
    expect_val("mid_rst_dbg5", 6, 0);
    expect_val("mid_rst_count", 4, 0);
    expect_val("mid_rst_busy6", 2, 0);
    cyc();
    rst = 1'b0;
    idle();
    expect_val("post_rst_dbg5", 6, 0);

    // bypass vs no bypass
    cyc();
    reg_write_enable = 1'b1; rd_addr = 5'd3; rd_data = 32'h12345678;
    rs_addr = {5'd0, 5'd3};
    expect_val("byp_same", 0, 32'h12345678);
    expect_val("nobyp_same", 7, 0);
    cyc();
    idle();
    expect_val("byp_next", 0, 32'h12345678);
    expect_val("nobyp_next", 7, 32'h12345678);

    // register zero
    cyc();
    reg_write_enable = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    rs_addr = {5'd0, 5'd0}; dbg_addr = 5'd0;
    expect_val("r0_ready", 5, 1);
    expect_val("r0_byp", 0, 0);
    cyc();
    idle();
    expect_val("r0_data", 0, 0);
    expect_val("r0_busy", 2, 0);
    expect_val("r0_count", 4, 0);
    expect_val("r0_dbg", 6, 0);

    // RAW stall on r7
    cyc();
    issue_valid = 1'b1; issue_rd = 5'd7;
    expect_val("raw_issue", 5, 1);
    cyc();
    rs_addr = {5'd7, 5'd0};
    expect_val("raw_busy", 3, 1);
    expect_val("raw_waw", 5, 0);
    expect_val("raw_cnt1", 4, 1);
    cyc();
    idle();
    reg_write_enable = 1'b1; rd_addr = 5'd7; rd_data = 32'h55;
    expect_val("raw_wb_busy", 3, 0);
    expect_val("raw_wb_nb_busy", 8, 1);
    expect_val("raw_wb_data", 1, 32'h55);
    expect_val("raw_wb_cnt", 4, 1);
    cyc();
    idle();
    expect_val("raw_cnt0", 4, 0);
    expect_val("raw_free", 3, 0);
    expect_val("raw_nb_free", 8, 0);

    // simultaneous release and issue of r9
    cyc();
    issue_valid = 1'b1; issue_rd = 5'd9;
    cyc();
    idle();
    expect_val("r9_cnt1", 4, 1);
    cyc();
    reg_write_enable = 1'b1; rd_addr = 5'd9; rd_data = 32'h99;
    issue_valid = 1'b1; issue_rd = 5'd9;
    expect_val("r9_ready", 5, 1);
    cyc();
    idle();
    rs_addr = {5'd0, 5'd9};
    expect_val("r9_cnt_keep", 4, 1);
    expect_val("r9_busy", 2, 1);
    expect_val("r9_data", 0, 32'h99);

    // flush with issue and concurrent write
    cyc();
    flush = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd10;
    reg_write_enable = 1'b1; rd_addr = 5'd11; rd_data = 32'hA5;
    expect_val("fl_ready", 5, 0);
    cyc();
    idle();
    rs_addr = {5'd11, 5'd10};
    expect_val("fl_cnt", 4, 0);
    expect_val("fl_r10", 2, 0);
    expect_val("fl_r11", 1, 32'hA5);
    cyc();
    rs_addr = {5'd0, 5'd9};
    expect_val("fl_r9", 2, 0);

    // fill all registers
    for (int i = 1; i < 32; i++) begin
      cyc();
      issue_valid = 1'b1; issue_rd = 5'(i);
      expect_val("fill_ready", 5, 1);
      expect_val("fill_cnt", 4, 32'(i - 1));
    end
    cyc();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd5;
    expect_val("full_cnt", 4, 31);
    expect_val("full_waw", 5, 0);

    // release all registers
    for (int i = 1; i < 32; i++) begin
      cyc();
      idle();
      reg_write_enable = 1'b1; rd_addr = 5'(i); rd_data = 32'(i);
      expect_val("drain_cnt", 4, 32'(32 - i));
    end
    cyc();
    idle();
    dbg_addr = 5'd5;
    issue_rd = 5'd5;
    expect_val("drain_cnt0", 4, 0);
    expect_val("drain_dbg5", 6, 32'd5);
    expect_val("drain_ready", 5, 1);

    cyc();
    cyc();
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
